// File: rtl/echo_char_tx_if.sv
// Byte-stream bundle between the RX path, the echo-enable flag and the UART TX core.
interface echo_char_tx_if;
  logic [7:0] RxData;
  logic       RxValid;
  logic       EchoEnable;
  logic       TxBusy;
  logic [7:0] TxData;
  logic       TxStart;
  logic       Overflow;
  logic       FifoEmpty;

  modport master (
    output RxData, RxValid, EchoEnable, TxBusy,
    input  TxData, TxStart, Overflow, FifoEmpty
  );

  modport slave (
    input  RxData, RxValid, EchoEnable, TxBusy,
    output TxData, TxStart, Overflow, FifoEmpty
  );
endinterface

// File: rtl/echo_char_tx.sv
// Echo transmitter: buffers received bytes while echo is on and replays them to the UART TX core.
// Optional ECHO_CRLF_EN: a transmitted CR (8'h0D) is followed by an injected LF (8'h0A).
module echo_char_tx #(
  parameter int unsigned ADDR_W = 3
) (
  input logic           Clock,
  input logic           Reset,
  echo_char_tx_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
`ifdef ECHO_CRLF_EN
    ,
    S_SEND_LF
`endif
  } state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              full_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic              overflow_q;
  logic              fifo_empty_q;

  state_t            state;
  state_t            state_next;
  logic [7:0]        tx_data_q;
  logic [7:0]        tx_data_d;
  logic              tx_start_q;
  logic              tx_start_d;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign full_c = (count == CNT_W'(DEPTH));
  assign push_c = bus.RxValid & bus.EchoEnable & (~full_c | pop_c);
  assign drop_c = bus.RxValid & bus.EchoEnable & full_c & ~pop_c;

  always_comb begin
    count_next = count;
    case ({push_c, pop_c})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push_c) begin
      mem[wr_ptr] <= bus.RxData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_q   <= 1'b0;
      fifo_empty_q <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + ADDR_W'(1);
      count        <= count_next;
      overflow_q   <= drop_c;
      fifo_empty_q <= (count_next == '0);
    end
  end

  // State register and registered TX outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state      <= state_next;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty_q && !bus.TxBusy) state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.TxBusy) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.TxBusy) begin
`ifdef ECHO_CRLF_EN
          state_next = (tx_data_q == 8'h0D) ? S_SEND_LF : S_IDLE;
`else
          state_next = S_IDLE;
`endif
        end
      end
`ifdef ECHO_CRLF_EN
      S_SEND_LF: begin
        if (!bus.TxBusy) state_next = S_WAIT_BUSY;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Launch decisions: pop and present the FIFO head, or inject the LF.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pop_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty_q && !bus.TxBusy) begin
          tx_data_d  = mem[rd_ptr];
          tx_start_d = 1'b1;
          pop_c      = 1'b1;
        end
      end
`ifdef ECHO_CRLF_EN
      S_SEND_LF: begin
        if (!bus.TxBusy) begin
          tx_data_d  = 8'h0A;
          tx_start_d = 1'b1;
        end
      end
`endif
      default: begin
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
      end
    endcase
  end

  assign bus.TxData    = tx_data_q;
  assign bus.TxStart   = tx_start_q;
  assign bus.Overflow  = overflow_q;
  assign bus.FifoEmpty = fifo_empty_q;

endmodule

// File: tb/tb_echo_char_tx.sv
// Directed bench for echo_char_tx with a simple UART TX busy model and a TxStart log.
module tb_echo_char_tx;

  logic Clock;
  logic Reset;
  echo_char_tx_if bus ();

  echo_char_tx #(.ADDR_W(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int   checks;
  int   errors;
  int   busy_len;
  int   busy_cnt;
  logic hold_busy;
  int   overlap;
  logic [7:0] log_q [$];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // TX core model: busy from the cycle after TxStart for busy_len cycles.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) busy_cnt <= 0;
    else if (bus.TxStart) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.TxBusy = (busy_cnt != 0) | hold_busy;

  always @(posedge Clock) begin
    if (!Reset && bus.TxStart) begin
      log_q.push_back(bus.TxData);
      if (bus.TxBusy) overlap <= overlap + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    checks = 0; errors = 0; overlap = 0;
    busy_len = 10; hold_busy = 1'b0;
    Reset = 1'b1;
    bus.RxData = 8'h00; bus.RxValid = 1'b0; bus.EchoEnable = 1'b0;
    run(2);
    check("rst_txdata",  bus.TxData, 8'h00);
    check("rst_txstart", 8'(bus.TxStart), 8'h00);
    check("rst_ovf",     8'(bus.Overflow), 8'h00);
    check("rst_empty",   8'(bus.FifoEmpty), 8'h01);
    Reset = 1'b0;
    run(2);

    // 1: single byte, two-cycle latency, single pulse
    bus.EchoEnable = 1'b1; bus.RxData = 8'h41; bus.RxValid = 1'b1;
    step();
    bus.RxValid = 1'b0;
    check("t1_start_c1", 8'(bus.TxStart), 8'h00);
    check("t1_empty_c1", 8'(bus.FifoEmpty), 8'h00);
    step();
    check("t1_start_c2", 8'(bus.TxStart), 8'h01);
    check("t1_data",     bus.TxData, 8'h41);
    check("t1_empty_c2", 8'(bus.FifoEmpty), 8'h01);
    step();
    check("t1_start_c3", 8'(bus.TxStart), 8'h00);
    check("t1_busy_c3",  8'(bus.TxBusy), 8'h01);
    run(20);
    check("t1_count", 8'(log_q.size()), 8'd1);
    check("t1_log0",  log_q[0], 8'h41);
    log_q.delete();

    // 2: echo off, then the enabling 'E' is not echoed
    bus.EchoEnable = 1'b0; bus.RxData = 8'h42; bus.RxValid = 1'b1;
    step();
    bus.RxValid = 1'b0;
    check("t2_empty_off", 8'(bus.FifoEmpty), 8'h01);
    bus.RxData = 8'h45; bus.RxValid = 1'b1;
    step();
    bus.RxValid = 1'b0; bus.EchoEnable = 1'b1;
    check("t2_empty_E", 8'(bus.FifoEmpty), 8'h01);
    run(10);
    check("t2_count", 8'(log_q.size()), 8'd0);

    // 3: overflow on the ninth byte while TX is held busy
    busy_len = 3; hold_busy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.RxData = 8'(8'hA0 + k); bus.RxValid = 1'b1;
      step();
      check($sformatf("t3_ovf%0d", k), 8'(bus.Overflow), (k == 8) ? 8'h01 : 8'h00);
    end
    bus.RxValid = 1'b0;
    step();
    check("t3_ovf_clear", 8'(bus.Overflow), 8'h00);
    check("t3_not_empty", 8'(bus.FifoEmpty), 8'h00);
    hold_busy = 1'b0;
    run(100);
    check("t3_count", 8'(log_q.size()), 8'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_log%0d", k), log_q[k], 8'(8'hA0 + k));
    end
    check("t3_empty_end", 8'(bus.FifoEmpty), 8'h01);
    log_q.delete();

    // 4: back-to-back pushes, order kept
    busy_len = 5;
    bus.RxData = 8'h31; bus.RxValid = 1'b1;
    step();
    bus.RxData = 8'h32;
    step();
    bus.RxValid = 1'b0;
    run(40);
    check("t4_count", 8'(log_q.size()), 8'd2);
    check("t4_log0",  log_q[0], 8'h31);
    check("t4_log1",  log_q[1], 8'h32);
    log_q.delete();

    // 5: reset during WAIT_DONE with three bytes queued
    busy_len = 20;
    for (int k = 0; k < 4; k++) begin
      bus.RxData = 8'(8'h51 + k); bus.RxValid = 1'b1;
      step();
    end
    bus.RxValid = 1'b0;
    check("t5_busy",      8'(bus.TxBusy), 8'h01);
    check("t5_not_empty", 8'(bus.FifoEmpty), 8'h00);
    Reset = 1'b1;
    #1;
    check("t5_rst_start", 8'(bus.TxStart), 8'h00);
    check("t5_rst_empty", 8'(bus.FifoEmpty), 8'h01);
    check("t5_rst_data",  bus.TxData, 8'h00);
    run(2);
    Reset = 1'b0;
    log_q.delete();
    run(40);
    check("t5_count", 8'(log_q.size()), 8'd0);

    // 6: carriage return
    busy_len = 3;
    bus.RxData = 8'h0D; bus.RxValid = 1'b1;
    step();
    bus.RxValid = 1'b0;
    run(30);
`ifdef ECHO_CRLF_EN
    check("t6_count", 8'(log_q.size()), 8'd2);
    check("t6_log0",  log_q[0], 8'h0D);
    check("t6_log1",  log_q[1], 8'h0A);
`else
    check("t6_count", 8'(log_q.size()), 8'd1);
    check("t6_log0",  log_q[0], 8'h0D);
`endif
    check("overlap", 8'(overlap), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
